// File: rtl/caf_peak_pkg.sv
// Shared definitions for the CAF peak detector.
// Holds the scan FSM state type and helpers that give the bit offsets of the
// fields in the result word {detect, freq_idx, lag_idx, peak_mag}, MSB first.
package caf_peak_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StHold
  } state_e;

  // LSB position of lag_idx in the result word.
  function automatic int unsigned lag_lsb(input int unsigned mag_bits);
    return mag_bits;
  endfunction

  // LSB position of freq_idx in the result word.
  function automatic int unsigned freq_lsb(input int unsigned mag_bits,
                                           input int unsigned lag_bits);
    return mag_bits + lag_bits;
  endfunction

  // Position of the detect flag, the result MSB.
  function automatic int unsigned detect_pos(input int unsigned mag_bits,
                                             input int unsigned lag_bits,
                                             input int unsigned freq_bits);
    return mag_bits + lag_bits + freq_bits;
  endfunction

endpackage

// File: rtl/caf_index_counter.sv
// Nested lag/frequency index counter for one ambiguity surface.
// lag_cnt and freq_cnt hold the coordinates of the cell currently on the input.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : advance by one cell (accepted beat)
//   clr        : synchronous clear (tlast beat); wins over inc
//   lag_cnt    : lag index, wraps LAG_LEN-1 -> 0 and carries into freq_cnt
//   freq_cnt   : frequency index, wraps FOA_LEN-1 -> 0
module caf_index_counter
  import caf_peak_pkg::*;
#(
  parameter int unsigned LAG_LEN   = 64,
  parameter int unsigned FOA_LEN   = 8,
  parameter int unsigned LAG_BITS  = $clog2(LAG_LEN),
  parameter int unsigned FREQ_BITS = $clog2(FOA_LEN)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc,
  input  logic                 clr,
  output logic [LAG_BITS-1:0]  lag_cnt,
  output logic [FREQ_BITS-1:0] freq_cnt
);

  localparam logic [LAG_BITS-1:0]  LagMax  = LAG_BITS'(LAG_LEN - 1);
  localparam logic [FREQ_BITS-1:0] FreqMax = FREQ_BITS'(FOA_LEN - 1);

  logic [LAG_BITS-1:0]  lag_q, lag_d;
  logic [FREQ_BITS-1:0] freq_q, freq_d;

  always_comb begin
    lag_d  = lag_q;
    freq_d = freq_q;
    if (clr) begin
      lag_d  = '0;
      freq_d = '0;
    end else if (inc) begin
      if (lag_q == LagMax) begin
        lag_d  = '0;
        freq_d = (freq_q == FreqMax) ? '0 : freq_q + 1'b1;
      end else begin
        lag_d = lag_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lag_q  <= '0;
      freq_q <= '0;
    end else begin
      lag_q  <= lag_d;
      freq_q <= freq_d;
    end
  end

  assign lag_cnt  = lag_q;
  assign freq_cnt = freq_q;

endmodule

// File: rtl/caf_peak_detect.sv
// CAF peak detector: scans one ambiguity surface of correlation-power cells
// (all lags of bin 0, then bin 1, ...) and emits one result beat with the
// peak power and its (frequency bin, lag) coordinates. tlast ends a surface.
// Optional feature macro: CAF_PEAK_THRESHOLD_EN adds the threshold port and
// sets detect = (peak_mag >= threshold); otherwise detect is always 1.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   m_axis_tdata  : input cell power (unsigned)
//   m_axis_tvalid : input cell valid
//   m_axis_tlast  : last cell of surface
//   s_axis_tready : input accepted (registered, low only while holding a result)
//   s_axis_tdata  : result {detect, freq_idx, lag_idx, peak_mag}
//   s_axis_tvalid : result valid, held until m_axis_tready
//   m_axis_tready : downstream accepts result
//   threshold     : detection threshold (CAF_PEAK_THRESHOLD_EN only)
module caf_peak_detect
  import caf_peak_pkg::*;
#(
  parameter int unsigned MAG_BITS  = 32,
  parameter int unsigned LAG_LEN   = 64,
  parameter int unsigned FOA_LEN   = 8,
  parameter int unsigned LAG_BITS  = $clog2(LAG_LEN),
  parameter int unsigned FREQ_BITS = $clog2(FOA_LEN)
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [MAG_BITS-1:0]                      m_axis_tdata,
  input  logic                                     m_axis_tvalid,
  input  logic                                     m_axis_tlast,
  output logic                                     s_axis_tready,
  output logic [1+FREQ_BITS+LAG_BITS+MAG_BITS-1:0] s_axis_tdata,
  output logic                                     s_axis_tvalid,
  input  logic                                     m_axis_tready
`ifdef CAF_PEAK_THRESHOLD_EN
  ,
  input  logic [MAG_BITS-1:0]                      threshold
`endif
);

  localparam int unsigned LagLsb    = lag_lsb(MAG_BITS);
  localparam int unsigned FreqLsb   = freq_lsb(MAG_BITS, LAG_BITS);
  localparam int unsigned DetectPos = detect_pos(MAG_BITS, LAG_BITS, FREQ_BITS);

  state_e               state_q, state_d;
  logic [MAG_BITS-1:0]  peak_mag_q, peak_mag_d;
  logic [LAG_BITS-1:0]  peak_lag_q, peak_lag_d;
  logic [FREQ_BITS-1:0] peak_freq_q, peak_freq_d;
  logic                 detect_q, detect_d;
  logic                 valid_q, valid_d;
  logic                 ready_q, ready_d;

  logic                 accept;
  logic [LAG_BITS-1:0]  lag_cnt;
  logic [FREQ_BITS-1:0] freq_cnt;

  assign accept = m_axis_tvalid & ready_q;

  caf_index_counter #(
    .LAG_LEN  (LAG_LEN),
    .FOA_LEN  (FOA_LEN),
    .LAG_BITS (LAG_BITS),
    .FREQ_BITS(FREQ_BITS)
  ) u_index_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (accept),
    .clr     (accept & m_axis_tlast),
    .lag_cnt (lag_cnt),
    .freq_cnt(freq_cnt)
  );

  always_comb begin
    state_d     = state_q;
    peak_mag_d  = peak_mag_q;
    peak_lag_d  = peak_lag_q;
    peak_freq_d = peak_freq_q;
    detect_d    = detect_q;
    valid_d     = valid_q;
    ready_d     = ready_q;
    unique case (state_q)
      StIdle, StScan: begin
        if (accept) begin
          // First cell of a surface always loads; later cells must be strictly
          // greater so ties keep the earliest cell.
          if ((state_q == StIdle) || (m_axis_tdata > peak_mag_q)) begin
            peak_mag_d  = m_axis_tdata;
            peak_lag_d  = lag_cnt;
            peak_freq_d = freq_cnt;
          end
          if (m_axis_tlast) begin
            state_d = StHold;
            valid_d = 1'b1;
            ready_d = 1'b0;
`ifdef CAF_PEAK_THRESHOLD_EN
            detect_d = (peak_mag_d >= threshold);
`else
            detect_d = 1'b1;
`endif
          end else begin
            state_d = StScan;
          end
        end
      end
      StHold: begin
        if (m_axis_tready) begin
          state_d = StIdle;
          valid_d = 1'b0;
          ready_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        valid_d = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      peak_mag_q  <= '0;
      peak_lag_q  <= '0;
      peak_freq_q <= '0;
      detect_q    <= 1'b0;
      valid_q     <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      peak_mag_q  <= peak_mag_d;
      peak_lag_q  <= peak_lag_d;
      peak_freq_q <= peak_freq_d;
      detect_q    <= detect_d;
      valid_q     <= valid_d;
      ready_q     <= ready_d;
    end
  end

  assign s_axis_tdata[MAG_BITS-1:0]         = peak_mag_q;
  assign s_axis_tdata[LagLsb +: LAG_BITS]   = peak_lag_q;
  assign s_axis_tdata[FreqLsb +: FREQ_BITS] = peak_freq_q;
  assign s_axis_tdata[DetectPos]            = detect_q;
  assign s_axis_tvalid                      = valid_q;
  assign s_axis_tready                      = ready_q;

endmodule

// File: tb/tb_caf_peak_detect.sv
// Scoreboard bench for caf_peak_detect with LAG_LEN=4, FOA_LEN=2.
module tb_caf_peak_detect;

  localparam int unsigned MagBits  = 32;
  localparam int unsigned LagLen   = 4;
  localparam int unsigned FoaLen   = 2;
  localparam int unsigned LagBits  = 2;
  localparam int unsigned FreqBits = 1;
  localparam int unsigned ResBits  = 1 + FreqBits + LagBits + MagBits;

  logic                clk;
  logic                rst_n;
  logic [MagBits-1:0]  m_axis_tdata;
  logic                m_axis_tvalid;
  logic                m_axis_tlast;
  logic                s_axis_tready;
  logic [ResBits-1:0]  s_axis_tdata;
  logic                s_axis_tvalid;
  logic                m_axis_tready;
`ifdef CAF_PEAK_THRESHOLD_EN
  logic [MagBits-1:0]  threshold;
`endif

  caf_peak_detect #(
    .MAG_BITS(MagBits),
    .LAG_LEN (LagLen),
    .FOA_LEN (FoaLen)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast (m_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .m_axis_tready(m_axis_tready)
`ifdef CAF_PEAK_THRESHOLD_EN
    ,
    .threshold    (threshold)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [ResBits-1:0] exp_q[$];

  // Reference model state
  bit                 m_first;
  int                 m_lag;
  int                 m_freq;
  logic [MagBits-1:0] m_peak;
  int                 m_plag;
  int                 m_pfreq;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [ResBits-1:0] pack(input logic det, input int freq, input int lag,
                                              input logic [MagBits-1:0] mag);
    logic [FreqBits-1:0] f;
    logic [LagBits-1:0]  l;
    f = FreqBits'(freq);
    l = LagBits'(lag);
    return {det, f, l, mag};
  endfunction

  task automatic model_clear();
    m_first = 1'b1;
    m_lag   = 0;
    m_freq  = 0;
  endtask

  // Result monitor: outputs are stable at negedge, handshake completes next posedge.
  always @(negedge clk) begin
    if (rst_n && s_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) check("result_expected", 64'(exp_q.size()), 64'd1);
      else check("result", 64'(s_axis_tdata), 64'(exp_q.pop_front()));
    end
  end

  // Drive one cell and wait (bounded) for it to be accepted.
  task automatic send(input logic [MagBits-1:0] mag, input bit last);
    bit accepted;
    logic det;
    m_axis_tvalid = 1'b1;
    m_axis_tdata  = mag;
    m_axis_tlast  = last;
    accepted = 1'b0;
    for (int i = 0; i < 200 && !accepted; i++) begin
      @(negedge clk);
      if (s_axis_tready) accepted = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!accepted) begin
      check("accept_timeout", 64'd0, 64'd1);
    end else begin
      if (m_first || mag > m_peak) begin
        m_peak  = mag;
        m_plag  = m_lag;
        m_pfreq = m_freq;
      end
      m_first = 1'b0;
      if (last) begin
`ifdef CAF_PEAK_THRESHOLD_EN
        det = (m_peak >= threshold);
`else
        det = 1'b1;
`endif
        exp_q.push_back(pack(det, m_pfreq, m_plag, m_peak));
        model_clear();
        check("valid_latency", 64'(s_axis_tvalid), 64'd1);
        check("ready_low_hold", 64'(s_axis_tready), 64'd0);
      end else begin
        m_lag++;
        if (m_lag == LagLen) begin
          m_lag = 0;
          m_freq++;
          if (m_freq == FoaLen) m_freq = 0;
        end
      end
    end
  endtask

  task automatic idle();
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tdata  = '0;
  endtask

  // Wait for all expected results to be consumed, then check ready recovery.
  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_pending", 64'(exp_q.size()), 64'd0);
    check("ready_after_result", 64'(s_axis_tready), 64'd1);
    check("valid_after_result", 64'(s_axis_tvalid), 64'd0);
  endtask

  task automatic send_surface(input logic [MagBits-1:0] vals[$]);
    for (int i = 0; i < vals.size(); i++) send(vals[i], i == vals.size() - 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 64'(s_axis_tready), 64'd1);
    check("rst_valid", 64'(s_axis_tvalid), 64'd0);
    check("rst_data", 64'(s_axis_tdata), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  logic [MagBits-1:0] surf[$];
  logic [ResBits-1:0] hold_exp;

  initial begin
    rst_n         = 1'b1;
    m_axis_tready = 1'b1;
    idle();
`ifdef CAF_PEAK_THRESHOLD_EN
    threshold = '0;
`endif
    #2;
    do_reset();

    // Ascending 1..8: peak at last cell (freq 1, lag 3)
    surf = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
    send_surface(surf);
    idle();
    drain();

    // Tie: earliest of (0,1) and (1,2) wins
    surf = {32'd10, 32'd50, 32'd10, 32'd10, 32'd10, 32'd10, 32'd50, 32'd10};
    send_surface(surf);
    idle();
    drain();

    // Single zero-power cell, result held while downstream stalls
    m_axis_tready = 1'b0;
    hold_exp = pack(1'b1, 0, 0, 32'd0);
    send(32'd0, 1'b1);
    idle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", 64'(s_axis_tvalid), 64'd1);
      check("hold_data", 64'(s_axis_tdata), 64'(hold_exp));
      check("hold_ready", 64'(s_axis_tready), 64'd0);
    end
    @(posedge clk);
    #1;
    m_axis_tready = 1'b1;
    drain();

    // Reset mid-surface after 99 seen; partial surface must vanish
    send(32'd3, 1'b0);
    send(32'd99, 1'b0);
    send(32'd5, 1'b0);
    idle();
    do_reset();
    surf = {32'd1, 32'd2, 32'd7, 32'd4, 32'd0, 32'd6, 32'd3, 32'd2};
    send_surface(surf);
    idle();
    drain();

    // Full-width unsigned comparison
    surf = {32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFE};
    send_surface(surf);
    idle();
    drain();

    // Longer than LagLen*FoaLen: indices wrap, peak at cell 8 -> (0,0)
    surf = {32'd5, 32'd5, 32'd5, 32'd5, 32'd5, 32'd5, 32'd5, 32'd5, 32'd200, 32'd5};
    send_surface(surf);
    idle();
    drain();

`ifdef CAF_PEAK_THRESHOLD_EN
    threshold = 32'd100;
    surf = {32'd20, 32'd99, 32'd40};
    send_surface(surf);
    idle();
    drain();
    surf = {32'd20, 32'd40, 32'd100};
    send_surface(surf);
    idle();
    drain();
    threshold = '0;
`endif

    // Back-to-back surfaces, tvalid held high across the HOLD stall
    m_axis_tready = 1'b0;
    fork
      begin
        surf = {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
        send_surface(surf);
        surf = {32'd3, 32'd3, 32'd3, 32'd9, 32'd3, 32'd3, 32'd3, 32'd3};
        send_surface(surf);
      end
      begin
        repeat (14) @(posedge clk);
        #1;
        m_axis_tready = 1'b1;
      end
    join
    idle();
    drain();

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
